// File: rtl/acc_multi_predecoder.sv
// ============================================================================
//  Module   : acc_multi_predecoder
//  Brief    : Registered multi-extension offload predecoder with fixed-priority
//             match resolution and a valid/ready response channel.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module acc_multi_predecoder #(
    parameter int unsigned NUM_EXT     = 2,
    parameter int unsigned NUM_INSTR   = 4,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned NUM_RS      = 3,
    parameter int unsigned NUM_WB      = 2,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned EXT_W       = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1,
    parameter logic [NUM_EXT*NUM_INSTR-1:0][INSTR_WIDTH-1:0] INSTR_DATA   = '1,
    parameter logic [NUM_EXT*NUM_INSTR-1:0][INSTR_WIDTH-1:0] INSTR_MASK   = '0,
    parameter logic [NUM_EXT*NUM_INSTR-1:0][NUM_RS-1:0]      INSTR_USE_RS = '0,
    parameter logic [NUM_EXT*NUM_INSTR-1:0][NUM_WB-1:0]      INSTR_WB     = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_EXT-1:0]     ext_en_i,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [INSTR_WIDTH-1:0] q_instr_data_i,
    input  logic [ID_WIDTH-1:0]    q_id_i,
    output logic                   p_valid_o,
    input  logic                   p_ready_i,
    output logic                   p_accept_o,
    output logic [EXT_W-1:0]       p_ext_o,
    output logic [NUM_RS-1:0]      p_use_rs_o,
    output logic [NUM_WB-1:0]      p_writeback_o,
    output logic                   p_multi_o,
    output logic [ID_WIDTH-1:0]    p_id_o,
    output logic                   conflict_o,
    input  logic                   conflict_clr_i
);

    localparam int unsigned c_num_entries = NUM_EXT * NUM_INSTR;

    logic [c_num_entries-1:0]        w_entry_match;
    logic [NUM_EXT-1:0]              w_ext_match;
    logic [NUM_EXT-1:0]              w_hit;
    logic [NUM_EXT-1:0][NUM_RS-1:0]  w_ext_rs;
    logic [NUM_EXT-1:0][NUM_WB-1:0]  w_ext_wb;
    logic                            w_accept;
    logic                            w_multi;
    logic [EXT_W-1:0]                w_ext;
    logic [NUM_RS-1:0]               w_rs;
    logic [NUM_WB-1:0]               w_wb;
    logic                            w_q_ready;
    logic                            w_capture;

    logic                            r_valid;
    logic                            r_accept;
    logic [EXT_W-1:0]                r_ext;
    logic [NUM_RS-1:0]               r_use_rs;
    logic [NUM_WB-1:0]               r_wb;
    logic                            r_multi;
    logic [ID_WIDTH-1:0]             r_id;
    logic                            r_conflict;

    // Padding entries (data bits outside the mask) can never satisfy this compare.
    generate
        for (genvar k = 0; k < c_num_entries; k++) begin : g_entry
            assign w_entry_match[k] = ((INSTR_MASK[k] & q_instr_data_i) == INSTR_DATA[k]);
        end
    endgenerate

    always_comb begin
        w_ext_match = '0;
        w_ext_rs    = '0;
        w_ext_wb    = '0;
        for (int e = 0; e < NUM_EXT; e++) begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                if (w_entry_match[e*NUM_INSTR+i]) begin
                    w_ext_match[e] = 1'b1;
                    w_ext_rs[e]    = w_ext_rs[e] | INSTR_USE_RS[e*NUM_INSTR+i];
                    w_ext_wb[e]    = w_ext_wb[e] | INSTR_WB[e*NUM_INSTR+i];
                end
            end
        end
    end

    assign w_hit = w_ext_match & ext_en_i;

    // Lowest-index hit wins; any later hit only flags a multi-match.
    always_comb begin
        w_accept = 1'b0;
        w_multi  = 1'b0;
        w_ext    = '0;
        w_rs     = '0;
        w_wb     = '0;
        for (int e = 0; e < NUM_EXT; e++) begin
            if (w_hit[e]) begin
                if (!w_accept) begin
                    w_accept = 1'b1;
                    w_ext    = EXT_W'(e);
                    w_rs     = w_ext_rs[e];
                    w_wb     = w_ext_wb[e];
                end else begin
                    w_multi  = 1'b1;
                end
            end
        end
    end

    assign w_q_ready = !rst_i && (!r_valid || p_ready_i);
    assign w_capture = q_valid_i && w_q_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_accept <= 1'b0;
            r_ext    <= '0;
            r_use_rs <= '0;
            r_wb     <= '0;
            r_multi  <= 1'b0;
            r_id     <= '0;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_accept <= w_accept;
            r_ext    <= w_ext;
            r_use_rs <= w_rs;
            r_wb     <= w_wb;
            r_multi  <= w_multi;
            r_id     <= q_id_i;
        end else if (p_ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflict <= 1'b0;
        end else if (w_capture && w_multi) begin
            r_conflict <= 1'b1;
        end else if (conflict_clr_i) begin
            r_conflict <= 1'b0;
        end
    end

    assign q_ready_o     = w_q_ready;
    assign p_valid_o     = r_valid;
    assign p_accept_o    = r_accept;
    assign p_ext_o       = r_ext;
    assign p_use_rs_o    = r_use_rs;
    assign p_writeback_o = r_wb;
    assign p_multi_o     = r_multi;
    assign p_id_o        = r_id;
    assign conflict_o    = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_acc_multi_predecoder.sv
// ============================================================================
//  Module   : tb_acc_multi_predecoder
//  Brief    : Scoreboard bench for acc_multi_predecoder using the two-extension
//             reference table.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_acc_multi_predecoder;

    localparam logic [7:0][31:0] c_data = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000002B, 32'h0000000B,
                                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000B};
    localparam logic [7:0][31:0] c_mask = {32'h0, 32'h0, 32'h0000007F, 32'h0000007F,
                                           32'h0, 32'h0, 32'h0, 32'h0000707F};
    localparam logic [7:0][2:0]  c_rs   = {3'b000, 3'b000, 3'b111, 3'b001,
                                           3'b000, 3'b000, 3'b000, 3'b011};
    localparam logic [7:0][1:0]  c_wb   = {2'b00, 2'b00, 2'b01, 2'b00,
                                           2'b00, 2'b00, 2'b00, 2'b01};

    typedef struct packed {
        logic       accept;
        logic       ext;
        logic [2:0] rs;
        logic [1:0] wb;
        logic       multi;
        logic [3:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ext_en = 2'b11;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [31:0] q_instr = '0;
    logic [3:0]  q_id = '0;
    logic        p_valid;
    logic        p_ready = 1'b1;
    logic        p_accept;
    logic [0:0]  p_ext;
    logic [2:0]  p_rs;
    logic [1:0]  p_wb;
    logic        p_multi;
    logic [3:0]  p_id;
    logic        conflict;
    logic        conflict_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    acc_multi_predecoder #(
        .NUM_EXT(2), .NUM_INSTR(4), .INSTR_WIDTH(32), .NUM_RS(3), .NUM_WB(2), .ID_WIDTH(4),
        .INSTR_DATA(c_data), .INSTR_MASK(c_mask), .INSTR_USE_RS(c_rs), .INSTR_WB(c_wb)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ext_en_i(ext_en),
        .q_valid_i(q_valid), .q_ready_o(q_ready), .q_instr_data_i(q_instr), .q_id_i(q_id),
        .p_valid_o(p_valid), .p_ready_i(p_ready), .p_accept_o(p_accept), .p_ext_o(p_ext),
        .p_use_rs_o(p_rs), .p_writeback_o(p_wb), .p_multi_o(p_multi), .p_id_o(p_id),
        .conflict_o(conflict), .conflict_clr_i(conflict_clr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic a, input logic x, input logic [2:0] r,
                                input logic [1:0] w, input logic m, input logic [3:0] id);
        exp_t e;
        e.accept = a; e.ext = x; e.rs = r; e.wb = w; e.multi = m; e.id = id;
        return e;
    endfunction

    // Every response handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (!rst && p_valid === 1'b1 && p_ready === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_response: actual id=%0d, required no response", p_id);
            end else begin
                e = sb.pop_front();
                a = mk(p_accept, p_ext[0], p_rs, p_wb, p_multi, p_id);
                if (a !== e)
                    begin
                        n_fail++;
                        $display("FAIL response: actual acc=%b ext=%b rs=%b wb=%b multi=%b id=%0d, required acc=%b ext=%b rs=%b wb=%b multi=%b id=%0d",
                                 a.accept, a.ext, a.rs, a.wb, a.multi, a.id,
                                 e.accept, e.ext, e.rs, e.wb, e.multi, e.id);
                    end
            end
        end
    end

    task automatic issue(input logic [31:0] instr, input logic [3:0] id, input exp_t e);
        q_valid = 1'b1; q_instr = instr; q_id = id;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (q_ready === 1'b1) begin
                sb.push_back(e);
                @(posedge clk); #1;
                q_valid = 1'b0;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL issue_timeout: actual q_ready=%b, required 1 within 50 cycles", q_ready);
        q_valid = 1'b0;
    endtask

    task automatic drain();
        p_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && p_valid === 1'b0) begin
                @(posedge clk); #1;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL drain_timeout: actual pending=%0d valid=%b, required 0 and 0", sb.size(), p_valid);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if ({p_valid, p_accept, p_ext, p_rs, p_wb, p_multi, p_id, conflict} !== '0) begin
            n_fail++;
            $display("FAIL %s: actual valid=%b acc=%b ext=%b rs=%b wb=%b multi=%b id=%0d conflict=%b, required all 0",
                     name, p_valid, p_accept, p_ext, p_rs, p_wb, p_multi, p_id, conflict);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_outputs");
        n_tests++;
        if (q_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_q_ready: actual %b, required 0", q_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (q_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_q_ready: actual %b, required 1", q_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        ext_en = 2'b11; p_ready = 1'b1;
        issue(32'h0000100B, 4'd3, mk(1'b1, 1'b1, 3'b001, 2'b00, 1'b0, 4'd3));
        @(negedge clk);
        n_tests++;
        if (p_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: actual valid=%b, required 1 one cycle after capture", p_valid);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_priority_conflict();
        issue(32'h0000000B, 4'd5, mk(1'b1, 1'b0, 3'b011, 2'b01, 1'b1, 4'd5));
        @(negedge clk);
        n_tests++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set: actual %b, required 1", conflict);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_sticky: actual %b, required 1", conflict);
        end
        @(posedge clk); #1;
        conflict_clr = 1'b1;
        @(posedge clk); #1;
        conflict_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_clear: actual %b, required 0", conflict);
        end
        @(posedge clk); #1;
        conflict_clr = 1'b1;
        issue(32'h0000000B, 4'd6, mk(1'b1, 1'b0, 3'b011, 2'b01, 1'b1, 4'd6));
        conflict_clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_set_wins: actual %b, required 1", conflict);
        end
        @(posedge clk); #1;
        conflict_clr = 1'b1;
        @(posedge clk); #1;
        conflict_clr = 1'b0;
        drain();
    endtask

    task automatic test_enable();
        ext_en = 2'b10;
        issue(32'h0000000B, 4'd7, mk(1'b1, 1'b1, 3'b001, 2'b00, 1'b0, 4'd7));
        ext_en = 2'b00;
        issue(32'h0000000B, 4'd8, mk(1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 4'd8));
        ext_en = 2'b11;
        drain();
        n_tests++;
        if (conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_no_conflict: actual %b, required 0", conflict);
        end
    endtask

    task automatic test_miss();
        issue(32'h00000033, 4'd9, mk(1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 4'd9));
        issue(32'h0000002B, 4'd4, mk(1'b1, 1'b1, 3'b111, 2'b01, 1'b0, 4'd4));
        drain();
    endtask

    task automatic test_back_to_back();
        p_ready = 1'b0;
        q_valid = 1'b1; q_instr = 32'h0000002B; q_id = 4'd1;
        @(negedge clk);
        n_tests++;
        if (q_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_ready: actual %b, required 1", q_ready);
        end
        sb.push_back(mk(1'b1, 1'b1, 3'b111, 2'b01, 1'b0, 4'd1));
        @(posedge clk); #1;
        q_instr = 32'h0000100B; q_id = 4'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({q_ready, p_valid, p_accept, p_ext, p_rs, p_wb, p_multi, p_id} !==
                {1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 2'b01, 1'b0, 4'd1}) begin
                n_fail++;
                $display("FAIL b2b_hold: actual q_ready=%b valid=%b acc=%b ext=%b rs=%b wb=%b multi=%b id=%0d, required 0 1 1 1 111 01 0 1",
                         q_ready, p_valid, p_accept, p_ext, p_rs, p_wb, p_multi, p_id);
            end
            @(posedge clk); #1;
        end
        p_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (q_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_release_ready: actual %b, required 1", q_ready);
        end
        sb.push_back(mk(1'b1, 1'b1, 3'b001, 2'b00, 1'b0, 4'd2));
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (p_valid !== 1'b1 || p_id !== 4'd2) begin
            n_fail++;
            $display("FAIL b2b_second: actual valid=%b id=%0d, required valid=1 id=2", p_valid, p_id);
        end
        @(posedge clk); #1;
        drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        p_ready = 1'b0;
        issue(32'h0000002B, 4'd10, mk(1'b1, 1'b1, 3'b111, 2'b01, 1'b0, 4'd10));
        @(negedge clk);
        n_tests++;
        if (p_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_held: actual valid=%b, required 1", p_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("midop_reset_outputs");
        n_tests++;
        if (sb.size() != 1) begin
            n_fail++;
            $display("FAIL midop_pending: actual %0d, required 1 dropped entry", sb.size());
        end
        sb.delete();
        @(posedge clk); #1;
        p_ready = 1'b1;
        issue(32'h0000100B, 4'd11, mk(1'b1, 1'b1, 3'b001, 2'b00, 1'b0, 4'd11));
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority_conflict();
        test_enable();
        test_miss();
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
